// File: rtl/huff_stream_encoder_pkg.sv
// Shared types and width helpers for the table-programmable Huffman stream encoder.
package huff_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Bits needed to hold the values 0..maxval inclusive.
  function automatic int width_for(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/huff_bit_packer.sv
// Left-justified bit accumulator: appends variable-length codes below the
// current fill and pops OUT_W-bit words off the top, MSB first.
module huff_bit_packer
  import huff_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int OUT_W   = 8,
  localparam int LEN_W  = width_for(MAX_LEN),
  localparam int NB_W   = width_for(OUT_W),
  localparam int AW     = OUT_W + MAX_LEN,
  localparam int FW     = width_for(OUT_W + MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               app_en,
  input  logic [MAX_LEN-1:0] app_code,
  input  logic [LEN_W-1:0]   app_len,
  input  logic               pop,
  output logic [FW-1:0]      fill,
  output logic [OUT_W-1:0]   word,
  output logic [NB_W-1:0]    word_nbits
);

  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_next;
  logic [AW-1:0]      base;
  logic [AW-1:0]      ins;
  logic [FW-1:0]      fill_q;
  logic [FW-1:0]      fill_next;
  logic [FW-1:0]      fill_b;
  logic [FW-1:0]      popped;
  logic [MAX_LEN-1:0] code_mask;
  logic [NB_W-1:0]    nb;

  // The pop is applied first so a same-cycle append lands just below the
  // surviving bits instead of inside the word that is leaving.
  always_comb begin
    popped    = (fill_q > FW'(OUT_W)) ? FW'(OUT_W) : fill_q;
    base      = acc;
    fill_b    = fill_q;
    if (pop) begin
      base   = acc << OUT_W;
      fill_b = fill_q - popped;
    end
    code_mask = ~({MAX_LEN{1'b1}} >> app_len);
    ins       = {app_code & code_mask, {OUT_W{1'b0}}} >> fill_b;
    acc_next  = base;
    fill_next = fill_b;
    if (app_en) begin
      acc_next  = base | ins;
      fill_next = fill_b + FW'(app_len);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      fill_q <= '0;
    end else begin
      acc    <= acc_next;
      fill_q <= fill_next;
    end
  end

  always_comb begin
    nb         = NB_W'(popped);
    word       = acc[AW-1 -: OUT_W] & ~({OUT_W{1'b1}} >> nb);
    word_nbits = nb;
    fill       = fill_q;
  end

endmodule

// File: rtl/huff_stream_encoder.sv
// Huffman encoder with a loadable code table; symbols in, MSB-first packed
// words out, both sides valid/ready with frame delimiting.
module huff_stream_encoder
  import huff_pkg::*;
#(
  parameter int SYM_W   = 4,
  parameter int MAX_LEN = 8,
  parameter int OUT_W   = 8,
  localparam int LEN_W  = width_for(MAX_LEN),
  localparam int NB_W   = width_for(OUT_W),
  localparam int FW     = width_for(OUT_W + MAX_LEN),
  localparam int DEPTH  = 2 ** SYM_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [SYM_W-1:0]   cfg_addr,
  input  logic [MAX_LEN-1:0] cfg_code,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SYM_W-1:0]   in_sym,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [NB_W-1:0]    out_nbits,
  output logic               out_last,
  output logic               busy,
  output logic               err_len0
);

  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } entry_t;

  entry_t           tbl [DEPTH];
  entry_t           ent;
  state_e           state;
  logic             up;
  logic             accept;
  logic             pop;
  logic [LEN_W-1:0] cfg_len_sat;
  logic [FW-1:0]    fill;
  logic [OUT_W-1:0] word;
  logic [NB_W-1:0]  word_nbits;

  // 'up' keeps in_ready low while reset is held, even though RUN/fill=0
  // would otherwise advertise readiness.
  always_comb begin
    ent         = tbl[in_sym];
    cfg_len_sat = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    busy        = (fill != '0) || (state != RUN);
    in_ready    = up && (state == RUN) && (fill < FW'(OUT_W));
    out_valid   = (state == FLUSH) || (fill >= FW'(OUT_W));
    out_last    = (state == FLUSH) && (fill <= FW'(OUT_W));
    out_data    = word;
    out_nbits   = out_valid ? word_nbits : '0;
    accept      = in_valid && in_ready;
    pop         = out_valid && out_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (cfg_we && !busy) begin
      tbl[cfg_addr] <= '{code: cfg_code, len: cfg_len_sat};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      up       <= 1'b0;
      err_len0 <= 1'b0;
    end else begin
      up       <= 1'b1;
      err_len0 <= accept && (ent.len == '0);
      case (state)
        RUN:     if (accept && in_last) state <= FLUSH;
        FLUSH:   if (pop && out_last) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  huff_bit_packer #(
    .MAX_LEN (MAX_LEN),
    .OUT_W   (OUT_W)
  ) u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .app_en     (accept),
    .app_code   (ent.code),
    .app_len    (ent.len),
    .pop        (pop),
    .fill       (fill),
    .word       (word),
    .word_nbits (word_nbits)
  );

endmodule

// File: tb/tb_huff_stream_encoder.sv
// Scoreboard bench for huff_stream_encoder: stimulus pushes expected words,
// a negedge monitor pops and compares each word the DUT hands over.
module tb_huff_stream_encoder;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_code = '0;
  logic [3:0] cfg_len = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_sym = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_nbits;
  logic       out_last;
  logic       busy;
  logic       err_len0;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] nbits;
    logic       last;
  } word_t;

  word_t exp_q[$];
  word_t mon_exp;
  int    checks = 0;
  int    fails = 0;
  int    err_seen = 0;
  int    err_mark;

  always #5 clock = ~clock;

  huff_stream_encoder #(.SYM_W(4), .MAX_LEN(8), .OUT_W(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_code  (cfg_code),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_last  (out_last),
    .busy      (busy),
    .err_len0  (err_len0)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every handshake-completing word is compared against the queue head.
  always @(negedge clock) begin
    if (reset_n && err_len0) err_seen++;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_word: got data 0x%0h nbits %0d last %0d, expected no word",
                 out_data, out_nbits, out_last);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("word_data", out_data, mon_exp.data);
        check_output("word_nbits", out_nbits, mon_exp.nbits);
        check_output("word_last", out_last, mon_exp.last);
      end
    end
  end

  task automatic push_exp(input logic [7:0] data, input int nbits, input logic last);
    exp_q.push_back('{data: data, nbits: 4'(nbits), last: last});
  endtask

  task automatic write_cfg(input int addr, input logic [7:0] code, input int len);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_code = code;
    cfg_len  = 4'(len);
    @(posedge clock);
    #1 cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus(input int sym, input logic last);
    int n;
    in_valid = 1'b1;
    in_sym   = 4'(sym);
    in_last  = last;
    for (n = 0; n < 200; n++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    if (n == 200) check_output("accept_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clock);
      if (!busy && !out_valid && exp_q.size() == 0) break;
    end
    check_output(name, (n < 300) ? 1 : 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_in_ready"}, in_ready, 0);
    check_output({tag, "_out_valid"}, out_valid, 0);
    check_output({tag, "_out_data"}, out_data, 0);
    check_output({tag, "_out_nbits"}, out_nbits, 0);
    check_output({tag, "_out_last"}, out_last, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_err_len0"}, err_len0, 0);
  endtask

  task automatic load_table();
    write_cfg(0, 8'h00, 1);
    write_cfg(1, 8'hBF, 2);
    write_cfg(2, 8'hC0, 3);
    write_cfg(3, 8'hE0, 3);
    write_cfg(6, 8'hA5, 15);
  endtask

  initial begin
    #2 check_reset_outputs("reset");
    #20;
    @(posedge clock);
    #1 reset_n = 1'b1;
    load_table();

    $display("[TB] basic frame");
    push_exp(8'h5B, 8, 1'b0);
    push_exp(8'h80, 1, 1'b1);
    apply_stimulus(0, 1'b0);
    apply_stimulus(1, 1'b0);
    apply_stimulus(2, 1'b0);
    apply_stimulus(3, 1'b1);
    wait_idle("basic_idle");

    $display("[TB] exact fill and saturated length");
    push_exp(8'h00, 8, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(0, i == 7);
    wait_idle("exact_idle");
    push_exp(8'hA5, 8, 1'b1);
    apply_stimulus(6, 1'b1);
    wait_idle("sat_idle");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    push_exp(8'h5B, 8, 1'b0);
    push_exp(8'h80, 1, 1'b1);
    apply_stimulus(0, 1'b0);
    apply_stimulus(1, 1'b0);
    apply_stimulus(2, 1'b0);
    apply_stimulus(3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_output("hold_valid", out_valid, 1);
      check_output("hold_data", out_data, 8'h5B);
      check_output("hold_nbits", out_nbits, 8);
      check_output("hold_last", out_last, 0);
      check_output("hold_in_ready", in_ready, 0);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    wait_idle("bp_idle");

    out_ready = 1'b0;
    push_exp(8'hFF, 8, 1'b0);
    push_exp(8'h80, 2, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(3, 1'b0);
    @(negedge clock);
    check_output("full_in_ready", in_ready, 0);
    check_output("full_out_valid", out_valid, 1);
    check_output("full_data", out_data, 8'hFF);
    @(posedge clock);
    #1;
    fork
      apply_stimulus(0, 1'b1);
      begin
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle("bp2_idle");

    $display("[TB] length-0 entry");
    err_mark = err_seen;
    push_exp(8'h5B, 8, 1'b0);
    push_exp(8'h80, 1, 1'b1);
    apply_stimulus(0, 1'b0);
    apply_stimulus(5, 1'b0);
    apply_stimulus(1, 1'b0);
    apply_stimulus(2, 1'b0);
    apply_stimulus(3, 1'b1);
    wait_idle("len0_idle");
    check_output("len0_err_pulses", err_seen - err_mark, 1);
    err_mark = err_seen;
    push_exp(8'h00, 0, 1'b1);
    apply_stimulus(5, 1'b1);
    wait_idle("len0_alone_idle");
    check_output("len0_alone_err", err_seen - err_mark, 1);

    $display("[TB] config while busy");
    push_exp(8'h5B, 8, 1'b0);
    push_exp(8'h80, 1, 1'b1);
    apply_stimulus(0, 1'b0);
    write_cfg(0, 8'hC0, 2);
    apply_stimulus(1, 1'b0);
    apply_stimulus(2, 1'b0);
    apply_stimulus(3, 1'b1);
    wait_idle("cfg_busy_idle");
    write_cfg(0, 8'hC0, 2);
    push_exp(8'hFF, 8, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(0, i == 3);
    wait_idle("cfg_idle_idle");

    $display("[TB] reset mid-frame");
    apply_stimulus(1, 1'b0);
    apply_stimulus(2, 1'b0);
    reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    #20;
    @(posedge clock);
    #1 reset_n = 1'b1;
    err_mark = err_seen;
    push_exp(8'h00, 0, 1'b1);
    apply_stimulus(0, 1'b1);
    wait_idle("post_reset_idle");
    check_output("post_reset_err", err_seen - err_mark, 1);

    check_output("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
